hex_display_scanner: RTL and testbench

- Upstream stage of the 4-bit hex-to-7-segment decoder.
- Holds a 16-bit display value and time-multiplexes it across a 4-digit common-anode display.
- Each digit slot presents one nibble to the decoder inputs and drives the matching active-low anode.
- Value updates are deferred to a frame boundary so a displayed frame never mixes old and new digits, and optional leading-zero blanking is applied.

---
 rtl/hex_display_scanner.sv | 157 +++++++++++++++
 tb/tb_hex_display_scanner.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: holds a 16-bit display value and time-multiplexes its four
// nibbles onto a 4-digit common-anode display feeding a hex-to-7-segment decoder.
// New values are staged in a pending register and committed only at a frame boundary.
// Optional leading-zero blanking is applied to digits 3..1.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   enable         1 = scanning, 0 = display dark and scan counters held at 0
//   load           one-cycle strobe capturing value into the pending register
//   value[15:0]    display value, [3:0] = digit 0 (rightmost)
//   blank_lz       1 = suppress leading zeros on digits 3..1
//   nibble[3:0]    hex digit for the decoder
//   an[3:0]        active-low one-hot anode enables, an[i] selects digit i
//   digit_blank    1 = current slot is blanked
//   frame_start    one-cycle pulse after the digit index wraps from 3 to 0
//   update_pending 1 = a loaded value waits for the next frame boundary
module hex_display_scanner #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic [3:0]  nibble,
  output logic [3:0]  an,
  output logic        digit_blank,
  output logic        frame_start,
  output logic        update_pending
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      active_q, active_d;
  logic [15:0]      pending_q, pending_d;
  logic             pend_flag_q, pend_flag_d;
  logic [3:0]       nibble_q, nibble_d;
  logic [3:0]       an_q, an_d;
  logic             digit_blank_q, digit_blank_d;
  logic             frame_start_q, frame_start_d;

  logic       tick;
  logic       boundary;
  logic [3:0] cur_nibble;
  logic       lz_zero;
  logic       slot_blank;

  assign tick     = enable && (cnt_q == CntMax);
  assign boundary = tick && (idx_q == 2'd3);

  // Scan counters, value staging and frame-boundary commit.
  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    active_d      = active_q;
    pending_d     = pending_q;
    pend_flag_d   = pend_flag_q;
    frame_start_d = 1'b0;

    if (load) begin
      pending_d = value;
    end

    if (!enable) begin
      // Display is dark, so there is no frame to protect: commit at once.
      cnt_d = '0;
      idx_d = '0;
      if (load) begin
        active_d    = value;
        pend_flag_d = 1'b0;
      end else if (pend_flag_q) begin
        active_d    = pending_q;
        pend_flag_d = 1'b0;
      end
    end else begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        idx_d = idx_q + 2'd1;
      end
      frame_start_d = boundary;
      if (boundary) begin
        // A load on the boundary itself beats the older pending value.
        if (load) begin
          active_d = value;
        end else if (pend_flag_q) begin
          active_d = pending_q;
        end
        pend_flag_d = 1'b0;
      end else if (load) begin
        pend_flag_d = 1'b1;
      end
    end
  end

  assign cur_nibble = active_q[{idx_q, 2'b00} +: 4];

  // A digit is a leading zero when it and every digit to its left are zero.
  always_comb begin
    lz_zero = 1'b0;
    case (idx_q)
      2'd3:    lz_zero = (active_q[15:12] == 4'h0);
      2'd2:    lz_zero = (active_q[15:8] == 8'h00);
      2'd1:    lz_zero = (active_q[15:4] == 12'h000);
      default: lz_zero = 1'b0;
    endcase
  end

  assign slot_blank = blank_lz && lz_zero;

  // Output stage: registered, one cycle behind idx/active.
  always_comb begin
    an_d          = 4'b1111;
    nibble_d      = 4'h0;
    digit_blank_d = 1'b1;
    if (enable && !slot_blank) begin
      an_d          = ~(4'b0001 << idx_q);
      nibble_d      = cur_nibble;
      digit_blank_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      active_q      <= '0;
      pending_q     <= '0;
      pend_flag_q   <= 1'b0;
      nibble_q      <= 4'h0;
      an_q          <= 4'b1111;
      digit_blank_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      pend_flag_q   <= pend_flag_d;
      nibble_q      <= nibble_d;
      an_q          <= an_d;
      digit_blank_q <= digit_blank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign nibble         = nibble_q;
  assign an             = an_q;
  assign digit_blank    = digit_blank_q;
  assign frame_start    = frame_start_q;
  assign update_pending = pend_flag_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Testbench for hex_display_scanner with REFRESH_DIV=4. Expected output snapshots are
// queued against the clock cycle they belong to; a monitor compares at each falling edge.
// Edge numbers e count rising edges after reset release (e=1 is the first).
module tb_hex_display_scanner;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        digit_blank;
  logic        frame_start;
  logic        update_pending;

  hex_display_scanner #(
    .REFRESH_DIV(4),
    .CNT_W      (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .load          (load),
    .value         (value),
    .blank_lz      (blank_lz),
    .nibble        (nibble),
    .an            (an),
    .digit_blank   (digit_blank),
    .frame_start   (frame_start),
    .update_pending(update_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int         cyc;
    int         e;
    logic [3:0] an;
    logic [3:0] nib;
    logic       db;
    logic       fs;
    logic       up;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   base  = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int e, input logic [3:0] an_e, input logic [3:0] nib_e,
                           input logic db_e, input logic fs_e, input logic up_e);
    exp_t it;
    int   pos;
    it.cyc = base + e;
    it.e   = e;
    it.an  = an_e;
    it.nib = nib_e;
    it.db  = db_e;
    it.fs  = fs_e;
    it.up  = up_e;
    pos = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].cyc > it.cyc) begin
        pos = i;
        break;
      end
    end
    q.insert(pos, it);
  endtask

  task automatic wait_edge(input int e);
    while (cyc < base + e) @(negedge clk);
  endtask

  // Monitor: compare every snapshot that falls due at this falling edge.
  always @(negedge clk) begin
    exp_t it;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      it = q.pop_front();
      total++;
      if (it.cyc != cyc) begin
        bad++;
        $display("FAIL late_e%0d: checked at cycle %0d, required cycle %0d", it.e, cyc, it.cyc);
      end else if ({an, nibble, digit_blank, frame_start, update_pending} !==
                   {it.an, it.nib, it.db, it.fs, it.up}) begin
        bad++;
        $display("FAIL out_e%0d: got an=%b nib=%h db=%b fs=%b up=%b, need an=%b nib=%h db=%b fs=%b up=%b",
                 it.e, an, nibble, digit_blank, frame_start, update_pending,
                 it.an, it.nib, it.db, it.fs, it.up);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b1;
    load     = 1'b0;
    value    = 16'h0000;
    blank_lz = 1'b0;

    // Reset state while rst_n is held low.
    expect_at(1, 4'b1111, 4'h0, 1'b0, 1'b0, 1'b0);
    expect_at(2, 4'b1111, 4'h0, 1'b0, 1'b0, 1'b0);
    while (cyc < 3) @(negedge clk);
    rst_n = 1'b1;
    base  = cyc;

    // Scan order with active=0, each slot held 4 cycles, frame_start after edge 16.
    expect_at(1,  4'b1110, 4'h0, 1'b0, 1'b0, 1'b0);
    expect_at(4,  4'b1110, 4'h0, 1'b0, 1'b0, 1'b0);
    expect_at(5,  4'b1101, 4'h0, 1'b0, 1'b0, 1'b0);
    expect_at(9,  4'b1011, 4'h0, 1'b0, 1'b0, 1'b0);
    expect_at(13, 4'b0111, 4'h0, 1'b0, 1'b0, 1'b0);
    expect_at(16, 4'b0111, 4'h0, 1'b0, 1'b1, 1'b0);
    expect_at(17, 4'b1110, 4'h0, 1'b0, 1'b0, 1'b0);

    // Load 12AF in the digit-1 slot; old digits remain until the boundary at edge 32.
    expect_at(22, 4'b1101, 4'h0, 1'b0, 1'b0, 1'b1);
    expect_at(26, 4'b1011, 4'h0, 1'b0, 1'b0, 1'b1);
    expect_at(30, 4'b0111, 4'h0, 1'b0, 1'b0, 1'b1);
    expect_at(32, 4'b0111, 4'h0, 1'b0, 1'b1, 1'b0);
    expect_at(33, 4'b1110, 4'hF, 1'b0, 1'b0, 1'b0);
    wait_edge(21); load = 1'b1; value = 16'h12AF;
    wait_edge(22); load = 1'b0;

    // Two loads in one frame: only 2222 reaches the display.
    expect_at(36, 4'b1110, 4'hF, 1'b0, 1'b0, 1'b1);
    expect_at(37, 4'b1101, 4'hA, 1'b0, 1'b0, 1'b1);
    expect_at(44, 4'b1011, 4'h2, 1'b0, 1'b0, 1'b1);
    expect_at(48, 4'b0111, 4'h1, 1'b0, 1'b1, 1'b0);
    expect_at(49, 4'b1110, 4'h2, 1'b0, 1'b0, 1'b0);
    expect_at(53, 4'b1101, 4'h2, 1'b0, 1'b0, 1'b0);
    expect_at(57, 4'b1011, 4'h2, 1'b0, 1'b0, 1'b0);
    expect_at(61, 4'b0111, 4'h2, 1'b0, 1'b0, 1'b0);
    wait_edge(34); load = 1'b1; value = 16'h1111;
    wait_edge(35); load = 1'b0;
    wait_edge(39); load = 1'b1; value = 16'h2222;
    wait_edge(40); load = 1'b0;

    // Load 0ABC exactly on the boundary edge 64: immediate, never pending.
    expect_at(64, 4'b0111, 4'h2, 1'b0, 1'b1, 1'b0);
    expect_at(65, 4'b1110, 4'hC, 1'b0, 1'b0, 1'b0);
    expect_at(69, 4'b1101, 4'hB, 1'b0, 1'b0, 1'b0);
    expect_at(73, 4'b1011, 4'hA, 1'b0, 1'b0, 1'b0);
    expect_at(77, 4'b0111, 4'h0, 1'b0, 1'b0, 1'b0);
    wait_edge(63); load = 1'b1; value = 16'h0ABC;
    wait_edge(64); load = 1'b0;

    // Leading-zero blanking: takes effect immediately on 0ABC, then 0005.
    expect_at(79, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b1);
    expect_at(80, 4'b1111, 4'h0, 1'b1, 1'b1, 1'b0);
    expect_at(81, 4'b1110, 4'h5, 1'b0, 1'b0, 1'b0);
    expect_at(85, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    expect_at(89, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    wait_edge(77); load = 1'b1; value = 16'h0005;
    wait_edge(78); load = 1'b0; blank_lz = 1'b1;

    // Value 0000: digit 0 still shows 0.
    expect_at(93,  4'b1111, 4'h0, 1'b1, 1'b0, 1'b1);
    expect_at(96,  4'b1111, 4'h0, 1'b1, 1'b1, 1'b0);
    expect_at(97,  4'b1110, 4'h0, 1'b0, 1'b0, 1'b0);
    expect_at(101, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    wait_edge(89); load = 1'b1; value = 16'h0000;
    wait_edge(90); load = 1'b0;

    // Value 0100: only digit 3 blanked.
    expect_at(103, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b1);
    expect_at(112, 4'b1111, 4'h0, 1'b1, 1'b1, 1'b0);
    expect_at(113, 4'b1110, 4'h0, 1'b0, 1'b0, 1'b0);
    expect_at(117, 4'b1101, 4'h0, 1'b0, 1'b0, 1'b0);
    expect_at(121, 4'b1011, 4'h1, 1'b0, 1'b0, 1'b0);
    expect_at(125, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    wait_edge(101); load = 1'b1; value = 16'h0100;
    wait_edge(102); load = 1'b0;

    // Disable with 4321 pending: dark, committed at once, restart at digit 0.
    expect_at(131, 4'b1110, 4'h0, 1'b0, 1'b0, 1'b1);
    expect_at(134, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    expect_at(137, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    expect_at(138, 4'b1110, 4'h1, 1'b0, 1'b0, 1'b0);
    expect_at(141, 4'b1110, 4'h1, 1'b0, 1'b0, 1'b0);
    expect_at(142, 4'b1101, 4'h2, 1'b0, 1'b0, 1'b0);
    wait_edge(129); load = 1'b1; value = 16'h4321;
    wait_edge(130); load = 1'b0;
    wait_edge(133); enable = 1'b0;
    wait_edge(137); enable = 1'b1;

    // Asynchronous reset mid-slot with 9999 pending: cleared without a clock edge.
    expect_at(146, 4'b1011, 4'h3, 1'b0, 1'b0, 1'b1);
    expect_at(148, 4'b1111, 4'h0, 1'b0, 1'b0, 1'b0);
    expect_at(149, 4'b1110, 4'h0, 1'b0, 1'b0, 1'b0);
    expect_at(165, 4'b1110, 4'h0, 1'b0, 1'b0, 1'b0);
    expect_at(169, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    wait_edge(144); load = 1'b1; value = 16'h9999;
    wait_edge(145); load = 1'b0;
    wait_edge(147);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #5 rst_n = 1'b1;

    wait_edge(172);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    while (q.size() > 0) begin
      exp_t it;
      it = q.pop_front();
      total++;
      bad++;
      $display("FAIL unchecked_e%0d: never compared, required cycle %0d", it.e, it.cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
